fastdac_dpram_loader: RTL and testbench
=======================================

FASTDAC_DPRAM_LOADER -- requirements
Module: fastdac_dpram_loader

Interface
REQ-001 SHALL have parameters: SEQ_AW, default 10, sequence DPRAM address width; RNG_AW, default 12, RNG DPRAM address width; DW, default 32, data width.
REQ-002 SHALL have ports:
- s_axis_clk  in  1  sole clock.
- s_axis_tresetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have control ports:
- start  in  1  load-start pulse.
- abort  in  1  return-to-idle pulse.
- seq_max_addr  in  SEQ_AW  last sequence address.
- rng_max_addr  in  RNG_AW  last RNG address.
- rng_continuous  in  1  keep refilling RNG in RUN.
REQ-004 SHALL have host write ports:
- host_wen  in  1  host write strobe.
- host_sel  in  1  0=sequence RAM, 1=RNG RAM.
- host_addr  in  RNG_AW  host write address.
- host_din  in  DW  host write data.
REQ-005 SHALL have stream ports:
- s_axis_tdata  in  DW  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
REQ-006 SHALL have RAM write ports:
- fastdac_sequence_wen_int  out  1  sequence write enable.
- fastdac_sequence_addr_int  out  SEQ_AW  sequence write address.
- fastdac_sequence_din_int  out  DW  sequence write data.
- fastdac_rng_wen_int  out  1  RNG write enable.
- fastdac_rng_addr_int  out  RNG_AW  RNG write address.
- fastdac_rng_din_int  out  DW  RNG write data.
REQ-007 SHALL have status ports:
- dac1_shift_en_o  out  1  high once both RAMs are loaded.
- busy  out  1  high when state is not IDLE.
- wrap_cnt  out  16  count of RNG refill wraps.

Function
REQ-008 SHALL implement states IDLE, SEQ, RNG, RUN.
REQ-009 SHALL leave IDLE for SEQ on start; start SHALL be ignored outside IDLE.
REQ-010 SHALL, on abort in any state, enter IDLE next cycle and clear the address counters, dac1_shift_en_o and wrap_cnt; abort SHALL win over a simultaneous start.
REQ-011 SHALL drive s_axis_tready combinationally high when state is SEQ or RNG, or RUN with rng_continuous=1, and host_wen=0.
REQ-012 SHALL accept a stream beat only when tvalid and tready are both high.
REQ-013 SHALL give host writes priority: with host_wen=1 the stream is stalled that cycle and no beat is lost.
REQ-014 SHALL, in SEQ, write each accepted beat to sequence address seq_cnt (starting at 0, +1 per beat), and on the beat with seq_cnt==seq_max_addr clear seq_cnt and enter RNG.
REQ-015 SHALL, in RNG, write each accepted beat to RNG address rng_cnt (starting at 0), and on the beat with rng_cnt==rng_max_addr clear rng_cnt, enter RUN and set dac1_shift_en_o.
REQ-016 SHALL, in RUN with rng_continuous=1, keep writing RNG beats with rng_cnt wrapping max->0; each wrap SHALL increment wrap_cnt, saturating at 16'hFFFF.
REQ-017 SHALL, in RUN with rng_continuous=0, hold tready low and keep rng_cnt unchanged; rng_continuous 0->1 SHALL resume at the held rng_cnt.
REQ-018 SHALL route host writes in any state: host_sel=0 writes host_addr[SEQ_AW-1:0] to the sequence port; host_sel=1 writes host_addr to the RNG port; host writes SHALL NOT change the counters.
REQ-019 SHALL register all RAM write outputs; latency from accepted beat or host strobe to wen is exactly 1 cycle, with wen high for 1 cycle per write.
REQ-020 SHALL allow at most one write per port per cycle; wen SHALL be 0 on cycles without an accepted write.
REQ-021 SHALL treat seq_max_addr=0 or rng_max_addr=0 as a single-word phase.
REQ-022 SHALL sample max-address inputs at every compare, not latch them.
REQ-023 SHALL drive busy high whenever state is not IDLE.

Reset
REQ-024 SHALL, with s_axis_tresetn low, asynchronously force state IDLE, all counters 0, all wen/addr/din outputs 0, dac1_shift_en_o 0, wrap_cnt 0 and s_axis_tready 0.
REQ-025 SHALL, when reset is asserted mid-load, discard partial progress; after release, start SHALL reload from address 0.

Verification
REQ-026 SHALL cover: seq_max_addr=3, rng_max_addr=7, start, 12 back-to-back beats -> seq addr 0..3 then rng addr 0..7 written one cycle after each beat, dac1_shift_en_o rising the cycle after beat 12.
REQ-027 SHALL cover: host_wen=1, host_sel=1, addr 12'h005, din 32'hA5A5A5A5 during RNG with tvalid=1 -> tready=0 that cycle, RNG write of A5A5A5A5 to address 5, stream beat accepted next cycle at unchanged rng_cnt.
REQ-028 SHALL cover: RUN, rng_continuous=1, rng_max_addr=1, 6 beats -> addresses 0,1,0,1,0,1 written and wrap_cnt=3.
REQ-029 SHALL cover: abort while in RNG after 2 beats -> IDLE next cycle, busy=0, dac1_shift_en_o=0; a new start rewrites sequence address 0 first.
REQ-030 SHALL cover: reset asserted in SEQ after 2 beats -> all outputs 0 immediately, without waiting for a clock edge; start after release writes sequence address 0.
REQ-031 SHALL cover: start and abort asserted together in IDLE -> state remains IDLE.

Source files
------------

// File: rtl/fastdac_dpram_loader.sv
// Fast-DAC DPRAM loader: streams one sequence table and then one RNG table
// into two DPRAM write ports. While running it can keep refilling the RNG
// table. Host writes to either RAM take priority over the stream.
module fastdac_dpram_loader #(
    parameter int SEQ_AW = 10,
    parameter int RNG_AW = 12,
    parameter int DW     = 32
) (
    input  logic              s_axis_clk,
    input  logic              s_axis_tresetn,
    // control
    input  logic              start,
    input  logic              abort,
    input  logic [SEQ_AW-1:0] seq_max_addr,
    input  logic [RNG_AW-1:0] rng_max_addr,
    input  logic              rng_continuous,
    // host write
    input  logic              host_wen,
    input  logic              host_sel,
    input  logic [RNG_AW-1:0] host_addr,
    input  logic [DW-1:0]     host_din,
    // stream
    input  logic [DW-1:0]     s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    // RAM write ports
    output logic              fastdac_sequence_wen_int,
    output logic [SEQ_AW-1:0] fastdac_sequence_addr_int,
    output logic [DW-1:0]     fastdac_sequence_din_int,
    output logic              fastdac_rng_wen_int,
    output logic [RNG_AW-1:0] fastdac_rng_addr_int,
    output logic [DW-1:0]     fastdac_rng_din_int,
    // status
    output logic              dac1_shift_en_o,
    output logic              busy,
    output logic [15:0]       wrap_cnt
);

    typedef enum logic [1:0] {IDLE, SEQ, RNG, RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [SEQ_AW-1:0] r_seq_cnt, w_seq_cnt_nxt;
    logic [RNG_AW-1:0] r_rng_cnt, w_rng_cnt_nxt;
    logic [15:0]       r_wrap_cnt, w_wrap_cnt_nxt;
    logic              r_shift_en, w_shift_en_nxt;
    logic              w_accept;

    // Stream is open in the load phases (and RUN when refilling), stalled by host writes
    always_comb begin
        s_axis_tready = 1'b0;
        if ((r_state == SEQ) || (r_state == RNG) || ((r_state == RUN) && rng_continuous))
            s_axis_tready = ~host_wen;
    end

    assign w_accept        = s_axis_tvalid & s_axis_tready;
    assign busy            = (r_state != IDLE);
    assign wrap_cnt        = r_wrap_cnt;
    assign dac1_shift_en_o = r_shift_en;

    // Next-state, address counters, wrap counter and shift-enable
    always_comb begin
        w_state_nxt    = r_state;
        w_seq_cnt_nxt  = r_seq_cnt;
        w_rng_cnt_nxt  = r_rng_cnt;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_shift_en_nxt = r_shift_en;
        if (abort) begin
            w_state_nxt    = IDLE;
            w_seq_cnt_nxt  = '0;
            w_rng_cnt_nxt  = '0;
            w_wrap_cnt_nxt = '0;
            w_shift_en_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) w_state_nxt = SEQ;
                SEQ: if (w_accept) begin
                    if (r_seq_cnt == seq_max_addr) begin
                        w_seq_cnt_nxt = '0;
                        w_state_nxt   = RNG;
                    end else begin
                        w_seq_cnt_nxt = r_seq_cnt + 1'b1;
                    end
                end
                RNG: if (w_accept) begin
                    if (r_rng_cnt == rng_max_addr) begin
                        w_rng_cnt_nxt  = '0;
                        w_state_nxt    = RUN;
                        w_shift_en_nxt = 1'b1;
                    end else begin
                        w_rng_cnt_nxt = r_rng_cnt + 1'b1;
                    end
                end
                RUN: if (w_accept) begin
                    if (r_rng_cnt == rng_max_addr) begin
                        w_rng_cnt_nxt = '0;
                        if (r_wrap_cnt != 16'hFFFF) w_wrap_cnt_nxt = r_wrap_cnt + 16'd1;
                    end else begin
                        w_rng_cnt_nxt = r_rng_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
        if (!s_axis_tresetn) begin
            r_state    <= IDLE;
            r_seq_cnt  <= '0;
            r_rng_cnt  <= '0;
            r_wrap_cnt <= '0;
            r_shift_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq_cnt  <= w_seq_cnt_nxt;
            r_rng_cnt  <= w_rng_cnt_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
            r_shift_en <= w_shift_en_nxt;
        end
    end

    // Registered RAM write ports; host and stream never collide since host stalls the stream
    always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
        if (!s_axis_tresetn) begin
            fastdac_sequence_wen_int  <= 1'b0;
            fastdac_sequence_addr_int <= '0;
            fastdac_sequence_din_int  <= '0;
            fastdac_rng_wen_int       <= 1'b0;
            fastdac_rng_addr_int      <= '0;
            fastdac_rng_din_int       <= '0;
        end else begin
            fastdac_sequence_wen_int <= 1'b0;
            fastdac_rng_wen_int      <= 1'b0;
            if (host_wen) begin
                if (!host_sel) begin
                    fastdac_sequence_wen_int  <= 1'b1;
                    fastdac_sequence_addr_int <= host_addr[SEQ_AW-1:0];
                    fastdac_sequence_din_int  <= host_din;
                end else begin
                    fastdac_rng_wen_int  <= 1'b1;
                    fastdac_rng_addr_int <= host_addr;
                    fastdac_rng_din_int  <= host_din;
                end
            end else if (w_accept) begin
                if (r_state == SEQ) begin
                    fastdac_sequence_wen_int  <= 1'b1;
                    fastdac_sequence_addr_int <= r_seq_cnt;
                    fastdac_sequence_din_int  <= s_axis_tdata;
                end else begin
                    fastdac_rng_wen_int  <= 1'b1;
                    fastdac_rng_addr_int <= r_rng_cnt;
                    fastdac_rng_din_int  <= s_axis_tdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fastdac_dpram_loader.sv
// Self-checking bench for fastdac_dpram_loader: directed scenarios plus a
// randomized run, all checked cycle by cycle against a behavioural model.
module tb_fastdac_dpram_loader;
    localparam int SEQ_AW = 10;
    localparam int RNG_AW = 12;
    localparam int DW     = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 0, abort = 0, cont = 0;
    logic [SEQ_AW-1:0] smax = 0;
    logic [RNG_AW-1:0] rmax = 0;
    logic              hwen = 0, hsel = 0;
    logic [RNG_AW-1:0] haddr = 0;
    logic [DW-1:0]     hdin = 0, tdata = 0;
    logic              tvalid = 0;
    logic              tready, swen, rwen, shen, bsy;
    logic [SEQ_AW-1:0] saddr;
    logic [RNG_AW-1:0] raddr;
    logic [DW-1:0]     sdin, rdin;
    logic [15:0]       wcnt;

    fastdac_dpram_loader #(.SEQ_AW(SEQ_AW), .RNG_AW(RNG_AW), .DW(DW)) dut (
        .s_axis_clk(clk), .s_axis_tresetn(rst_n),
        .start(start), .abort(abort), .seq_max_addr(smax), .rng_max_addr(rmax),
        .rng_continuous(cont),
        .host_wen(hwen), .host_sel(hsel), .host_addr(haddr), .host_din(hdin),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .fastdac_sequence_wen_int(swen), .fastdac_sequence_addr_int(saddr),
        .fastdac_sequence_din_int(sdin),
        .fastdac_rng_wen_int(rwen), .fastdac_rng_addr_int(raddr), .fastdac_rng_din_int(rdin),
        .dac1_shift_en_o(shen), .busy(bsy), .wrap_cnt(wcnt)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phase 0=idle 1=loading sequence 2=loading rng 3=running
    int          m_phase, m_seq, m_rng, m_wrap;
    bit          m_en;
    bit          e_swen, e_rwen;
    int unsigned e_saddr, e_raddr;
    logic [DW-1:0] e_sdin, e_rdin;

    task automatic model_reset();
        m_phase = 0; m_seq = 0; m_rng = 0; m_wrap = 0; m_en = 0;
        e_swen = 0; e_rwen = 0; e_saddr = 0; e_raddr = 0; e_sdin = 0; e_rdin = 0;
    endtask

    function automatic bit model_ready();
        bit open;
        open = (m_phase == 1) || (m_phase == 2) || (m_phase == 3 && cont);
        return open && !hwen;
    endfunction

    task automatic model_clock();
        bit acc;
        acc = tvalid && model_ready();
        e_swen = 0; e_rwen = 0;
        if (hwen) begin
            if (!hsel) begin
                e_swen = 1; e_saddr = haddr % (1 << SEQ_AW); e_sdin = hdin;
            end else begin
                e_rwen = 1; e_raddr = haddr; e_rdin = hdin;
            end
        end else if (acc) begin
            if (m_phase == 1) begin
                e_swen = 1; e_saddr = m_seq; e_sdin = tdata;
            end else begin
                e_rwen = 1; e_raddr = m_rng; e_rdin = tdata;
            end
        end
        if (abort) begin
            m_phase = 0; m_seq = 0; m_rng = 0; m_wrap = 0; m_en = 0;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (acc && m_phase == 1) begin
            if (m_seq == int'(smax)) begin m_seq = 0; m_phase = 2; end
            else m_seq = (m_seq + 1) % (1 << SEQ_AW);
        end else if (acc) begin
            if (m_rng == int'(rmax)) begin
                m_rng = 0;
                if (m_phase == 2) begin m_phase = 3; m_en = 1; end
                else if (m_wrap < 65535) m_wrap++;
            end else m_rng = (m_rng + 1) % (1 << RNG_AW);
        end
    endtask

    task automatic check_outs();
        chk("seq_wen", swen, e_swen);
        chk("seq_addr", saddr, e_saddr);
        chk("seq_din", sdin, e_sdin);
        chk("rng_wen", rwen, e_rwen);
        chk("rng_addr", raddr, e_raddr);
        chk("rng_din", rdin, e_rdin);
        chk("shift_en", shen, m_en);
        chk("busy", bsy, m_phase != 0);
        chk("wrap_cnt", wcnt, m_wrap);
    endtask

    // One clock: called at a negedge with inputs already driven
    task automatic cycle();
        #1;
        chk("tready", tready, model_ready());
        model_clock();
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic quiet();
        start = 0; abort = 0; hwen = 0; tvalid = 0;
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    task automatic pulse_abort();
        abort = 1; cycle(); abort = 0;
    endtask

    task automatic beats(input int n);
        tvalid = 1;
        for (int i = 0; i < n; i++) begin
            tdata = $urandom;
            cycle();
        end
        tvalid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"}, tready, 0);
        chk({tag, "_swen"}, swen, 0);
        chk({tag, "_saddr"}, saddr, 0);
        chk({tag, "_sdin"}, sdin, 0);
        chk({tag, "_rwen"}, rwen, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_rdin"}, rdin, 0);
        chk({tag, "_shen"}, shen, 0);
        chk({tag, "_busy"}, bsy, 0);
        chk({tag, "_wrap"}, wcnt, 0);
    endtask

    initial begin
        model_reset();
        // reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // full load: 4 sequence words then 8 rng words
        smax = 3; rmax = 7; cont = 0;
        pulse_start();
        beats(12);
        chk("shift_en_after_load", shen, 1);
        tvalid = 1; tdata = $urandom;
        cycle();
        chk("run_hold_no_write", rwen, 0);
        tvalid = 0;
        pulse_abort();

        // host write during RNG load stalls the stream, no beat lost
        smax = 1; rmax = 7;
        pulse_start();
        beats(4);
        hwen = 1; hsel = 1; haddr = 12'h005; hdin = 32'hA5A5A5A5; tvalid = 1; tdata = $urandom;
        cycle();
        chk("host_rng_addr", raddr, 12'h005);
        chk("host_rng_din", rdin, 32'hA5A5A5A5);
        hwen = 0;
        cycle();
        chk("stream_after_host", raddr, 2);
        tvalid = 0;
        beats(5);
        chk("rng_done", shen, 1);

        // continuous refill with two-word table
        cont = 1; rmax = 1;
        beats(6);
        chk("wrap3", wcnt, 3);
        cont = 0;
        pulse_abort();

        // abort mid-RNG then restart from sequence address 0
        smax = 1; rmax = 7;
        pulse_start();
        beats(4);
        pulse_abort();
        chk("abort_busy", bsy, 0);
        chk("abort_shen", shen, 0);
        pulse_start();
        beats(1);
        chk("restart_addr", saddr, 0);
        chk("restart_wen", swen, 1);
        pulse_abort();

        // asynchronous reset mid-sequence
        smax = 3;
        pulse_start();
        beats(2);
        tvalid = 1;
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_rst");
        tvalid = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        pulse_start();
        beats(1);
        chk("post_rst_addr", saddr, 0);

        // start and abort together in idle
        pulse_abort();
        start = 1; abort = 1;
        cycle();
        quiet();
        chk("start_abort_idle", bsy, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom % 15 == 0);
            abort  = ($urandom % 60 == 0);
            hwen   = ($urandom % 5 == 0);
            hsel   = $urandom % 2;
            haddr  = $urandom;
            hdin   = $urandom;
            tvalid = ($urandom % 3 != 0);
            tdata  = $urandom;
            if ($urandom % 8 == 0) cont = $urandom % 2;
            if ($urandom % 40 == 0) smax = $urandom % 6;
            if ($urandom % 40 == 0) rmax = $urandom % 6;
            cycle();
        end
        quiet();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
